// File: rtl/k2mm_fifo_src.sv
// Multi-lane ap_fifo-style source: each lane streams num_words LFSR words to a popping consumer.
// Latency: first word visible one cycle after start; each lane sustains one pop per cycle.
module k2mm_fifo_src #(
  parameter int          LANES  = 8,
  parameter int          DATA_W = 32,
  parameter logic [31:0] SEED   = 32'hACE12468
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      start,
  input  logic [15:0]               num_words,
  output logic [LANES*DATA_W-1:0]   fifo_dout,
  output logic [LANES-1:0]          fifo_empty_n,
  input  logic [LANES-1:0]          fifo_read,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               checksum
);

  localparam logic [31:0] POLY = 32'h80200003;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [31:0] lfsr    [LANES];
  logic [15:0] rem     [LANES];
  logic [15:0] rem_nxt [LANES];
  logic [LANES-1:0] pop;
  logic [31:0] pop_xor;
  logic        all_zero;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? POLY : 32'h0);
  endfunction

  // An all-zero seed would lock the LFSR, so it is forced to 1.
  function automatic logic [31:0] lane_seed(input int i);
    logic [31:0] s;
    s = SEED ^ (32'(i + 1) << 24);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign fifo_dout[g*DATA_W +: DATA_W] = lfsr[g];
    assign fifo_empty_n[g]               = busy && (rem[g] != 16'h0);
  end

  always_comb begin
    pop      = fifo_read & fifo_empty_n;
    pop_xor  = 32'h0;
    all_zero = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      rem_nxt[i] = rem[i] - {15'h0, pop[i]};
      if (pop[i]) pop_xor = pop_xor ^ lfsr[i];
      if (rem_nxt[i] != 16'h0) all_zero = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      checksum <= 32'h0;
      for (int i = 0; i < LANES; i++) begin
        lfsr[i] <= 32'h0;
        rem[i]  <= 16'h0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            checksum <= 32'h0;
            for (int i = 0; i < LANES; i++) begin
              lfsr[i] <= lane_seed(i);
              rem[i]  <= num_words;
            end
            if (num_words == 16'h0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        RUN: begin
          checksum <= checksum ^ pop_xor;
          for (int i = 0; i < LANES; i++) begin
            if (pop[i]) begin
              lfsr[i] <= lfsr_step(lfsr[i]);
              rem[i]  <= rem_nxt[i];
            end
          end
          // Leave RUN on the edge that drains the final word so busy covers exactly the streaming cycles.
          if (all_zero) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_k2mm_fifo_src.sv
// Scoreboard bench for k2mm_fifo_src: model LFSR words queued per lane at start, compared on each pop.
module tb_k2mm_fifo_src;

  localparam int          LANES = 8;
  localparam logic [31:0] SEED  = 32'hACE12468;

  logic                  ap_clk;
  logic                  ap_rst;
  logic                  start;
  logic [15:0]           num_words;
  logic [LANES*32-1:0]   fifo_dout;
  logic [LANES-1:0]      fifo_empty_n;
  logic [LANES-1:0]      fifo_read;
  logic                  busy;
  logic                  done;
  logic [31:0]           checksum;

  k2mm_fifo_src #(.LANES(LANES), .DATA_W(32), .SEED(SEED)) dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .start        (start),
    .num_words    (num_words),
    .fifo_dout    (fifo_dout),
    .fifo_empty_n (fifo_empty_n),
    .fifo_read    (fifo_read),
    .busy         (busy),
    .done         (done),
    .checksum     (checksum)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [LANES][$];
  logic [31:0] cs_model;
  logic [31:0] cs_full;

  function automatic logic [31:0] model_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [31:0] model_seed(input int i);
    logic [31:0] s;
    s = SEED ^ (32'(i + 1) << 24);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: score any pops the current inputs cause, then advance past the edge.
  task automatic cyc();
    for (int i = 0; i < LANES; i++) begin
      if (fifo_read[i] && fifo_empty_n[i]) begin
        logic [31:0] w;
        w = fifo_dout[i*32 +: 32];
        if (exp_q[i].size() == 0) begin
          check($sformatf("extra_pop_lane%0d", i), 32'h1, 32'h0);
        end else begin
          check($sformatf("lane%0d_word", i), w, exp_q[i].pop_front());
        end
        cs_model = cs_model ^ w;
      end
    end
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    logic [31:0] x;
    cs_full  = 32'h0;
    cs_model = 32'h0;
    for (int i = 0; i < LANES; i++) begin
      exp_q[i].delete();
      x = model_seed(i);
      for (int k = 0; k < int'(n); k++) begin
        exp_q[i].push_back(x);
        cs_full = cs_full ^ x;
        x = model_step(x);
      end
    end
    start     = 1'b1;
    num_words = n;
    cyc();
    start     = 1'b0;
  endtask

  task automatic run_to_done(input int budget, input bit rnd);
    int c;
    c = 0;
    while (!done && c < budget) begin
      if (rnd) fifo_read = LANES'($urandom);
      cyc();
      c++;
    end
    check("done_reached", 32'(done), 32'h1);
    check("busy_low", 32'(busy), 32'h0);
    check("checksum_final", checksum, cs_full);
    check("checksum_vs_pops", checksum, cs_model);
    for (int i = 0; i < LANES; i++)
      check($sformatf("lane%0d_drained", i), 32'(exp_q[i].size()), 32'h0);
  endtask

  initial begin
    logic [31:0] w;
    int          cnt;
    ap_rst    = 1'b1;
    start     = 1'b0;
    num_words = 16'h0;
    fifo_read = '0;
    cs_model  = 32'h0;
    cs_full   = 32'h0;
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_empty_n", 32'(fifo_empty_n), 32'h0);
    check("rst_dout_any", 32'(|fifo_dout), 32'h0);
    check("rst_checksum", checksum, 32'h0);
    ap_rst = 1'b0;
    cyc();
    check("idle_empty_n", 32'(fifo_empty_n), 32'h0);

    // Two words on lane 0 with its read held high
    fifo_read = 8'h01;
    do_start(16'd2);
    check("first_word", fifo_dout[31:0], 32'hADE12468);
    check("first_empty_n0", 32'(fifo_empty_n[0]), 32'h1);
    check("first_busy", 32'(busy), 32'h1);
    cyc();
    check("second_word", fifo_dout[31:0], 32'h56F09234);
    cyc();
    check("lane0_exhausted", 32'(fifo_empty_n[0]), 32'h0);
    check("still_busy", 32'(busy), 32'h1);
    fifo_read = '1;
    run_to_done(20, 1'b0);

    // Zero-length run goes straight to DONE
    do_start(16'd0);
    check("zero_done", 32'(done), 32'h1);
    check("zero_busy", 32'(busy), 32'h0);
    check("zero_empty_n", 32'(fifo_empty_n), 32'h0);
    check("zero_checksum", checksum, 32'h0);

    // Full-rate on all lanes
    fifo_read = '1;
    do_start(16'd4);
    check("restart_done_cleared", 32'(done), 32'h0);
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      cyc();
    end
    check("busy_cycles", 32'(cnt), 32'd4);
    run_to_done(1, 1'b0);
    w = model_seed(0);
    repeat (4) w = model_step(w);
    repeat (3) cyc();
    check("done_checksum_hold", checksum, cs_full);
    check("done_empty_n", 32'(fifo_empty_n), 32'h0);
    check("done_dout_hold", fifo_dout[31:0], w);
    check("done_held", 32'(done), 32'h1);

    // Random per-lane throttling
    fifo_read = LANES'($urandom);
    do_start(16'd20);
    run_to_done(2000, 1'b1);
    fifo_read = '1;
    repeat (3) cyc();
    check("rand_checksum_hold", checksum, cs_full);

    // Start pulse during RUN is ignored
    fifo_read = '0;
    do_start(16'd6);
    cyc();
    cyc();
    start     = 1'b1;
    num_words = 16'd3;
    cyc();
    start     = 1'b0;
    check("ignored_start_busy", 32'(busy), 32'h1);
    check("ignored_start_dout0", fifo_dout[31:0], model_seed(0));
    fifo_read = '1;
    run_to_done(40, 1'b0);

    // Reset mid-RUN, then restart from the seed
    fifo_read = '1;
    do_start(16'd10);
    cyc();
    cyc();
    ap_rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_empty_n", 32'(fifo_empty_n), 32'h0);
    check("midrst_dout_any", 32'(|fifo_dout), 32'h0);
    check("midrst_checksum", checksum, 32'h0);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    for (int i = 0; i < LANES; i++) exp_q[i].delete();
    cyc();
    cyc();
    check("postrst_empty_n", 32'(fifo_empty_n), 32'h0);
    check("postrst_busy", 32'(busy), 32'h0);
    fifo_read = '0;
    do_start(16'd3);
    check("restart_word0", fifo_dout[31:0], 32'hADE12468);
    check("restart_word7", fifo_dout[7*32 +: 32], model_seed(7));
    fifo_read = '1;
    run_to_done(20, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/k2mm_fifo_src.md
K2MM_FIFO_SRC -- requirements
Module: k2mm_fifo_src

Interface
REQ-001 SHALL have parameter LANES, default 8, number of independent ap_fifo source lanes.
REQ-002 SHALL have parameter DATA_W, default 32, lane word width; only 32 is supported.
REQ-003 SHALL have parameter SEED, default 32'hACE12468, base LFSR seed.
REQ-004 SHALL have port ap_clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port ap_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle run request.
REQ-007 SHALL have port num_words  input  16  words per lane, sampled on accepted start.
REQ-008 SHALL have port fifo_dout  output  LANES*DATA_W  lane i word at bits [i*32+31:i*32].
REQ-009 SHALL have port fifo_empty_n  output  LANES  lane i has a valid word.
REQ-010 SHALL have port fifo_read  input  LANES  lane i consumer pop request.
REQ-011 SHALL have port busy  output  1  high in RUN.
REQ-012 SHALL have port done  output  1  high in DONE, held until next accepted start.
REQ-013 SHALL have port checksum  output  32  XOR of every word consumed on any lane since last accepted start.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL accept start only in IDLE or DONE; start in RUN is ignored.
REQ-016 On accepted start: load per-lane remaining count = num_words, lane i LFSR = SEED ^ ((i+1) << 24), clear checksum, clear done; next state RUN, or DONE if num_words == 0.
REQ-017 A seed that evaluates to 0 SHALL be replaced by 32'h00000001.
REQ-018 In RUN, fifo_empty_n[i] SHALL equal (remaining[i] != 0); fifo_dout lane i SHALL equal the lane i LFSR value.
REQ-019 First words SHALL be visible in the cycle after start is sampled (latency 1).
REQ-020 A pop SHALL occur on lane i when fifo_read[i] && fifo_empty_n[i] at a rising edge. On a pop: LFSR advances once, remaining decrements by 1, checksum ^= the popped word.
REQ-021 fifo_read[i] while fifo_empty_n[i] is low SHALL be ignored: no state change, no underflow.
REQ-022 LFSR advance SHALL be Galois right-shift: next = (x >> 1) ^ (x[0] ? 32'h80200003 : 0).
REQ-023 Lanes SHALL be fully independent and SHALL sustain one pop per lane per cycle with no bubbles; simultaneous pops on all lanes SHALL fold into checksum in the same cycle.
REQ-024 RUN SHALL transition to DONE in the cycle after the last remaining count reaches 0. busy SHALL fall and done SHALL rise together.
REQ-025 In IDLE and DONE, fifo_empty_n SHALL be all 0, and fifo_dout SHALL hold its last value.
REQ-026 checksum SHALL remain stable in DONE until the next accepted start.
REQ-027 start and a pop in the same cycle in DONE SHALL be resolved as start; the pop is impossible because empty_n is 0.

Reset
REQ-028 Asserting ap_rst at any time, including mid-RUN, SHALL immediately force: state IDLE, busy 0, done 0, fifo_empty_n 0, fifo_dout 0, checksum 0, counts 0, LFSRs 0.
REQ-029 After ap_rst deasserts, no lane SHALL present data until a new accepted start.

Verification
REQ-030 Apply reset, then start with num_words=2 and fifo_read[0] held high -> cycle+1: lane0 dout 32'hADE12468, empty_n[0]=1. Cycle+2: lane0 dout 32'h56F09234. Cycle+3: empty_n[0]=0.
REQ-031 Start with num_words=0 -> next cycle done=1, busy=0, empty_n=0, checksum=0.
REQ-032 Start with num_words=4, all reads high every cycle -> busy for exactly 4 cycles, then done=1. checksum equals the XOR of the 32 model LFSR words.
REQ-033 Random per-lane read throttling, plus reads while empty_n=0 -> each lane yields exactly num_words words matching the reference LFSR sequence, with no extra pops.
REQ-034 Assert ap_rst mid-RUN, then start again -> outputs are at reset values immediately, and the sequence restarts from the seed.
REQ-035 Pulse start during RUN -> ignored: counts and the LFSR sequence continue unchanged.
